unary_operand_serializer: RTL and testbench
===========================================

Name: unary_operand_serializer

Overview:
- Transmit end of the serial unary operand interface.
- Accepts two BIN_BITS-wide binary operands through a valid/ready handshake.
- Converts each operand to a thermometer-coded unary bit stream and drives the out_a/out_b/out_valid serial interface consumed by the unary shift multiplier.
- After each burst it holds off for a guard window sized to the worst-case product drain time of operand B, so the downstream multiplier always returns to its idle state before the next burst starts.

Parameters:
- BIN_BITS, 4, binary operand width; U_BITS = 2**BIN_BITS unary slots per burst.
- EXTRA_GUARD, 2, additional idle cycles appended to each guard window.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_a  input  BIN_BITS  binary operand A.
- in_b  input  BIN_BITS  binary operand B.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  serializer can accept a pair.
- out_a  output  1  serial unary A bit.
- out_b  output  1  serial unary B bit.
- out_valid  output  1  qualifies out_a/out_b; connects to the multiplier's in_valid.
- busy  output  1  high in SEND or GUARD.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; out_a=0, out_b=0, out_valid=0, busy=0; all counters and operand latches = 0.
- in_ready = (state==IDLE) && !reset. It is combinational from state and low while reset is asserted.
- Handshake: a transfer occurs at a rising edge where in_valid && in_ready. in_a/in_b are latched as a_q/b_q. Inputs are ignored at all other times, and in_valid may be held high across bursts.
- State machine states: IDLE, SEND, GUARD.
- IDLE -> SEND on transfer. Slot counter i is loaded to 0.
- SEND lasts exactly U_BITS cycles, immediately following the transfer edge. For slot i (0..U_BITS-1):
  - out_valid=1
  - out_a=(i<a_q)
  - out_b=(i<b_q)
  - Ones are emitted first, then zeros. All three outputs are registered.
- SEND -> GUARD after slot U_BITS-1. The guard counter is loaded with G=(b_q+1)*U_BITS+EXTRA_GUARD.
- GUARD lasts G cycles with out_valid=0, out_a=0, out_b=0. GUARD -> IDLE when the counter reaches 0.
- Latency: transfer at edge k -> first slot visible after edge k. in_ready is high again after edge k+U_BITS+G, so the earliest next transfer is at edge k+U_BITS+G+1.
- Arithmetic/width rules:
  - Slot counter: BIN_BITS bits; it wraps to 0 only on the SEND->GUARD transition.
  - Guard counter: 2*BIN_BITS+2 bits, holding a maximum of U_BITS*U_BITS+EXTRA_GUARD with no overflow.
  - Comparisons are unsigned.
- Boundary conditions:
  - a_q=0: out_a stays 0 for the whole burst; the burst still lasts U_BITS cycles.
  - b_q=0: out_b stays 0; G=U_BITS+EXTRA_GUARD (not shortened).
  - a_q=b_q=U_BITS-1: the last slot carries 0 on both lines.
  - Transfer with in_valid already high on the IDLE-entry cycle is accepted that cycle (no bubble).
- Reset mid-operation (SEND or GUARD): outputs drop to 0 asynchronously and state returns to IDLE. The partial burst is abandoned; the downstream multiplier must be reset together with this block.
- Synchronous inputs during reset have no effect.

Decomposition:
- Package unary_pkg holds:
  - the serializer state enum (IDLE, SEND, GUARD);
  - the function u_bits(bin_bits) returning 1<<bin_bits;
  - the function guard_len(b, bin_bits, extra).
- One natural sub-module, load_down_counter #(WIDTH). It has a load input, a load value, a decrement enable, an async active-high reset, and a zero flag output. It is used for the guard window.
- The slot counter stays inline.

Test Plan:
- BIN_BITS=4, in_a=3, in_b=2, single transfer at edge k:
  - out_valid high for 16 cycles; out_a=1,1,1 then 13 zeros; out_b=1,1 then 14 zeros.
  - in_ready returns after edge k+66 (G=50).
- in_a=0, in_b=5: out_a all 0 for 16 slots; out_b 5 ones then 11 zeros; G=98.
- in_a=15, in_b=0: out_a 15 ones, then slot 15 = 0; out_b all 0; G=18; busy high for exactly 34 cycles.
- in_valid held high with pairs (1,1) then (2,3):
  - second transfer occurs exactly one cycle after in_ready reasserts;
  - no overlap of bursts, and out_valid low throughout GUARD.
- Assert reset at SEND slot 7 of (9,9):
  - out_valid/out_a/out_b go to 0 immediately; in_ready is 0 during reset;
  - after release, state is IDLE and a new pair (4,4) produces a clean 16-slot burst.
- Full-range sweep a,b in 0..15, with the serializer driving the multiplier:
  - the count of ones on the multiplier output equals a*b for every pair;
  - the multiplier is idle at each next transfer.

Source files
------------

// File: rtl/unary_operand_serializer_pkg.sv
// Shared types and sizing helpers for the unary operand serializer.
package unary_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } ser_state_t;

    // Number of unary slots in one burst for a given binary width.
    function automatic int u_bits(input int bin_bits);
        return 1 << bin_bits;
    endfunction

    // Idle window after a burst: long enough for the multiplier to drain
    // every partial product of operand B, plus a small safety margin.
    function automatic int guard_len(input int b, input int bin_bits, input int extra);
        return ((b + 1) << bin_bits) + extra;
    endfunction

endpackage

// File: rtl/unary_operand_serializer_if.sv
// Operand handshake plus serial unary output bundle.
interface unary_operand_serializer_if #(
    parameter int BIN_BITS = 4
);
    logic [BIN_BITS-1:0] in_a;
    logic [BIN_BITS-1:0] in_b;
    logic                in_valid;
    logic                in_ready;
    logic                out_a;
    logic                out_b;
    logic                out_valid;
    logic                busy;

    // Operand producer / downstream observer side.
    modport master (
        output in_a,
        output in_b,
        output in_valid,
        input  in_ready,
        input  out_a,
        input  out_b,
        input  out_valid,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  in_a,
        input  in_b,
        input  in_valid,
        output in_ready,
        output out_a,
        output out_b,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/unary_operand_serializer_load_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
module load_down_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/unary_operand_serializer.sv
// Converts a pair of binary operands into thermometer-coded serial bursts
// followed by a guard window sized to the downstream multiplier drain time.
module unary_operand_serializer
    import unary_pkg::*;
#(
    parameter int BIN_BITS    = 4,
    parameter int EXTRA_GUARD = 2
) (
    input logic                          clk,
    input logic                          reset,
    unary_operand_serializer_if.slave    bus
);

    localparam int U_BITS  = u_bits(BIN_BITS);
    localparam int GUARD_W = 2 * BIN_BITS + 2;
    localparam logic [BIN_BITS-1:0] LAST_SLOT = BIN_BITS'(U_BITS - 1);

    ser_state_t          state;
    logic [BIN_BITS-1:0] slot;
    logic [BIN_BITS-1:0] a_q;
    logic [BIN_BITS-1:0] b_q;
    logic                out_a_r;
    logic                out_b_r;
    logic                out_valid_r;
    logic                busy_r;

    logic                transfer;
    logic                last_slot;
    logic [BIN_BITS:0]   next_slot;
    logic                guard_load;
    logic                guard_dec;
    logic                guard_zero;
    logic [GUARD_W-1:0]  guard_value;

    assign bus.in_ready = (state == IDLE) && !reset;
    assign transfer     = bus.in_valid && bus.in_ready;

    // slot always names the slot currently on the output registers, so the
    // next slot's bits are computed from slot+1 (one bit wider, never wraps).
    assign last_slot = (slot == LAST_SLOT);
    assign next_slot = {1'b0, slot} + (BIN_BITS + 1)'(1);

    // The counter is loaded with G-1 on the SEND->GUARD edge and the FSM
    // leaves GUARD on the edge where it already reads zero, giving exactly
    // G cycles of GUARD.
    assign guard_load  = (state == SEND) && last_slot;
    assign guard_dec   = (state == GUARD);
    assign guard_value = GUARD_W'(guard_len(int'(b_q), BIN_BITS, EXTRA_GUARD) - 1);

    load_down_counter #(
        .WIDTH (GUARD_W)
    ) u_guard_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (guard_load),
        .load_value (guard_value),
        .dec        (guard_dec),
        .zero       (guard_zero)
    );

    // Control FSM with registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_a_r     <= 1'b0;
            out_b_r     <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        a_q         <= bus.in_a;
                        b_q         <= bus.in_b;
                        slot        <= '0;
                        // Slot 0 goes out straight from the incoming operands.
                        out_valid_r <= 1'b1;
                        out_a_r     <= (bus.in_a != '0);
                        out_b_r     <= (bus.in_b != '0);
                        busy_r      <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (last_slot) begin
                        slot        <= '0;
                        out_valid_r <= 1'b0;
                        out_a_r     <= 1'b0;
                        out_b_r     <= 1'b0;
                        state       <= GUARD;
                    end else begin
                        slot    <= next_slot[BIN_BITS-1:0];
                        out_a_r <= (next_slot < {1'b0, a_q});
                        out_b_r <= (next_slot < {1'b0, b_q});
                    end
                end
                GUARD: begin
                    if (guard_zero) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_a     = out_a_r;
    assign bus.out_b     = out_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_unary_operand_serializer.sv
// Self-checking bench for unary_operand_serializer.
module tb_unary_operand_serializer;

    localparam int BIN_BITS    = 4;
    localparam int EXTRA_GUARD = 2;
    localparam int U           = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    unary_operand_serializer_if #(.BIN_BITS(BIN_BITS)) bus ();

    unary_operand_serializer #(
        .BIN_BITS    (BIN_BITS),
        .EXTRA_GUARD (EXTRA_GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int a;
        int b;
        int ones_a;
        int ones_b;
        int ready_after;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    // {out_valid, out_a, out_b, busy, in_ready}
    function automatic logic [4:0] snap();
        return {bus.out_valid, bus.out_a, bus.out_b, bus.busy, bus.in_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a burst is U slots of thermometer bits, then
    // G=(b+1)*U+EXTRA_GUARD quiet busy cycles, then idle with in_ready high.
    task automatic run_burst(input int a, input int b, input bit hold, input bit junk,
                             output int ones_a, output int ones_b);
        int g;
        logic [4:0] exp;
        g = (b + 1) * U + EXTRA_GUARD;
        check($sformatf("idle_before a=%0d b=%0d", a, b), 0, 32'(snap()), 32'(5'b00001));
        bus.in_a     = 4'(a);
        bus.in_b     = 4'(b);
        bus.in_valid = 1'b1;
        step();
        ones_a = 0;
        ones_b = 0;
        for (int c = 0; c < U + g; c++) begin
            if (c < U) exp = {1'b1, c < a, c < b, 1'b1, 1'b0};
            else       exp = 5'b00010;
            check($sformatf("burst a=%0d b=%0d cycle", a, b), c, 32'(snap()), 32'(exp));
            if (bus.out_valid) begin
                ones_a += int'(bus.out_a);
                ones_b += int'(bus.out_b);
            end
            if (!hold) bus.in_valid = 1'b0;
            if (junk) begin
                bus.in_a = 4'($urandom);
                bus.in_b = 4'($urandom);
            end
            step();
        end
    endtask

    // Transfer one pair and measure the burst against table constants.
    task automatic measure(input int idx);
        int cyc, nv, na, nb, nbusy;
        bit thermo_ok;
        logic prev_a, prev_b;
        bus.in_a     = 4'(vecs[idx].a);
        bus.in_b     = 4'(vecs[idx].b);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        cyc = 0; nv = 0; na = 0; nb = 0; nbusy = 0;
        thermo_ok = 1'b1; prev_a = 1'b1; prev_b = 1'b1;
        while (!bus.in_ready && cyc < 400) begin
            if (bus.out_valid) begin
                nv++;
                if (bus.out_a && !prev_a) thermo_ok = 1'b0;
                if (bus.out_b && !prev_b) thermo_ok = 1'b0;
                prev_a = bus.out_a;
                prev_b = bus.out_b;
                na += int'(bus.out_a);
                nb += int'(bus.out_b);
            end else if (bus.out_a || bus.out_b) begin
                thermo_ok = 1'b0;
            end
            if (bus.busy) nbusy++;
            cyc++;
            step();
        end
        check("tbl_ready_after", idx, 32'(cyc), 32'(vecs[idx].ready_after));
        check("tbl_busy_cycles", idx, 32'(nbusy), 32'(vecs[idx].ready_after));
        check("tbl_valid_slots", idx, 32'(nv), 32'(U));
        check("tbl_ones_a", idx, 32'(na), 32'(vecs[idx].ones_a));
        check("tbl_ones_b", idx, 32'(nb), 32'(vecs[idx].ones_b));
        check("tbl_thermometer", idx, 32'(thermo_ok), 32'(1));
    endtask

    initial begin
        int oa, ob;
        int pairs[256];
        int tmp, j;
        bit hold;

        vecs[0] = '{a: 3,  b: 2, ones_a: 3,  ones_b: 2, ready_after: 66};
        vecs[1] = '{a: 0,  b: 5, ones_a: 0,  ones_b: 5, ready_after: 114};
        vecs[2] = '{a: 15, b: 0, ones_a: 15, ones_b: 0, ready_after: 34};
        vecs[3] = '{a: 1,  b: 1, ones_a: 1,  ones_b: 1, ready_after: 50};
        vecs[4] = '{a: 15, b: 15, ones_a: 15, ones_b: 15, ready_after: 274};

        // Reset with junk on the inputs: nothing may leak through.
        bus.in_a     = 4'd7;
        bus.in_b     = 4'd9;
        bus.in_valid = 1'b1;
        repeat (3) step();
        check("reset_state", 0, 32'(snap()), 32'(5'b00000));
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("after_reset", 0, 32'(snap()), 32'(5'b00001));

        // Table-driven directed vectors.
        for (int i = 0; i < 5; i++) begin
            measure(i);
            $display("vector %0d: a=%0d b=%0d done", i, vecs[i].a, vecs[i].b);
        end

        // in_valid held high across back-to-back pairs (1,1) then (2,3).
        run_burst(1, 1, 1'b1, 1'b1, oa, ob);
        run_burst(2, 3, 1'b0, 1'b1, oa, ob);
        check("held_product", 0, 32'(oa * ob), 32'(6));
        $display("held-valid sequence done");

        // Reset in the middle of a (9,9) burst at slot 7.
        bus.in_a     = 4'd9;
        bus.in_b     = 4'd9;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        check("slot7", 0, 32'(snap()), 32'(5'b11110));
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("reset_mid_burst", 0, 32'(snap()), 32'(5'b00000));
        repeat (3) step();
        check("reset_hold", 0, 32'(snap()), 32'(5'b00000));
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        run_burst(4, 4, 1'b0, 1'b0, oa, ob);
        check("post_reset_product", 0, 32'(oa * ob), 32'(16));
        $display("mid-burst reset sequence done");

        // Full-range sweep in random order with random gaps and holds.
        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            hold = (i < 255) && ($urandom_range(0, 1) == 1);
            run_burst(pairs[i] / 16, pairs[i] % 16, hold, 1'b1, oa, ob);
            check($sformatf("product a=%0d b=%0d", pairs[i] / 16, pairs[i] % 16), i,
                  32'(oa * ob), 32'((pairs[i] / 16) * (pairs[i] % 16)));
            if (!hold) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
        end
        check("final_idle", 0, 32'(snap()), 32'(5'b00001));
        $display("sweep of 256 pairs done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
